// File: rtl/ex_stage_pipe.sv
// ---------------------------------------------------------------------------
// ex_stage_pipe
//
// Pipelined execute stage sitting between the ID/EX register and MEM.
// Computes the ALU result and resolves the next PC (jump-register, jump,
// conditional branch with selectable BEQ/BNE sense, or fall-through), then
// presents both in a registered EX/MEM output slot guarded by a valid/ready
// handshake. Multiplies run on an iterative shift-add unit that holds
// inReady low until the product has been written into the slot.
//
// Parameters:
//   DATA_W     datapath width (32 or 64)
//   MUL_STEPS  shift-add iterations per multiply (1..DATA_W, must divide
//              DATA_W evenly; each step consumes DATA_W/MUL_STEPS bits)
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   inValid/inReady  upstream handshake (accept = inValid && inReady)
//   incrPC           PC+4 of the instruction
//   regA, regB       rs / rt operands
//   extImm           sign-extended immediate
//   target           J-type target field
//   funct            R-type function field
//   aluOp            00 add, 01 sub, 10 decode funct, 11 or
//   aluSrc           1 selects extImm as operand B
//   branch/branchNe  conditional branch, 1 = BNE sense
//   jump, jumpR      J-type jump, jump to regA
//   flush            kill the output slot and any in-flight multiply
//   outReady         downstream accepts the slot
//   outValid         slot holds a result
//   aluResult        registered result
//   redirectValid    registered: instruction changes the PC
//   redirectPC       registered next PC
// ---------------------------------------------------------------------------
module ex_stage_pipe #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MUL_STEPS = DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inValid,
    output logic              inReady,
    input  logic [DATA_W-1:0] incrPC,
    input  logic [DATA_W-1:0] regA,
    input  logic [DATA_W-1:0] regB,
    input  logic [DATA_W-1:0] extImm,
    input  logic [25:0]       target,
    input  logic [5:0]        funct,
    input  logic [1:0]        aluOp,
    input  logic              aluSrc,
    input  logic              branch,
    input  logic              branchNe,
    input  logic              jump,
    input  logic              jumpR,
    input  logic              flush,
    input  logic              outReady,
    output logic              outValid,
    output logic [DATA_W-1:0] aluResult,
    output logic              redirectValid,
    output logic [DATA_W-1:0] redirectPC
);

    localparam int unsigned STEP_BITS = DATA_W / MUL_STEPS;
    localparam int unsigned CNT_W     = $clog2(MUL_STEPS + 1);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_STEPS - 1);

    // FSM encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [5:0] FN_MULT = 6'h18;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    logic [1:0]        state;
    logic [CNT_W-1:0]  stepCnt;

    // Multiplier working registers: mulA is the shifted multiplicand,
    // mulB the remaining multiplier bits, mulAcc the partial product.
    logic [DATA_W-1:0] mulA;
    logic [DATA_W-1:0] mulB;
    logic [DATA_W-1:0] mulAcc;
    logic [DATA_W-1:0] mulPC;

    logic [DATA_W-1:0] opB;
    logic [DATA_W-1:0] diff;
    logic [DATA_W-1:0] aluComb;
    logic [DATA_W-1:0] nextPC;
    logic [DATA_W-1:0] stepA;
    logic [DATA_W-1:0] stepB;
    logic [DATA_W-1:0] stepAcc;
    logic              zero;
    logic              sltBit;
    logic              branchTaken;
    logic              redirComb;
    logic              isMult;
    logic              slotFree;
    logic              accept;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign slotFree = !outValid || outReady;
    assign inReady  = (state == IDLE) && slotFree && !flush;
    assign accept   = inValid && inReady;

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    assign opB    = aluSrc ? extImm : regB;
    assign diff   = regA - opB;
    assign zero   = (diff == '0);
    assign sltBit = $signed(regA) < $signed(opB);

    always_comb begin
        aluComb = regA + opB;
        isMult  = 1'b0;
        case (aluOp)
            2'b00: aluComb = regA + opB;
            2'b01: aluComb = diff;
            2'b11: aluComb = regA | opB;
            default: begin
                case (funct)
                    FN_ADD:  aluComb = regA + opB;
                    FN_SUB:  aluComb = diff;
                    FN_AND:  aluComb = regA & opB;
                    FN_OR:   aluComb = regA | opB;
                    FN_SLT:  aluComb = {{(DATA_W-1){1'b0}}, sltBit};
                    FN_MULT: isMult  = 1'b1;
                    default: aluComb = regA + opB;
                endcase
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-PC resolution, priority jumpR > jump > taken branch > incrPC
    // ------------------------------------------------------------------
    assign branchTaken = branch && (branchNe ? !zero : zero);

    always_comb begin
        nextPC    = incrPC;
        redirComb = 1'b0;
        if (jumpR) begin
            nextPC    = regA;
            redirComb = 1'b1;
        end else if (jump) begin
            nextPC    = {incrPC[DATA_W-1:28], target, 2'b00};
            redirComb = 1'b1;
        end else if (branchTaken) begin
            nextPC    = incrPC + {extImm[DATA_W-3:0], 2'b00};
            redirComb = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // One multiplier step: consume STEP_BITS low bits of mulB. Shifting
    // copies instead of indexing keeps the loop free of variable selects.
    // ------------------------------------------------------------------
    always_comb begin
        stepAcc = mulAcc;
        stepA   = mulA;
        stepB   = mulB;
        for (int unsigned i = 0; i < STEP_BITS; i++) begin
            if (stepB[0]) begin
                stepAcc = stepAcc + stepA;
            end
            stepA = stepA << 1;
            stepB = stepB >> 1;
        end
    end

    // ------------------------------------------------------------------
    // Output slot and multiply FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            stepCnt       <= '0;
            mulA          <= '0;
            mulB          <= '0;
            mulAcc        <= '0;
            mulPC         <= '0;
            outValid      <= 1'b0;
            redirectValid <= 1'b0;
            aluResult     <= '0;
            redirectPC    <= '0;
        end else if (flush) begin
            outValid      <= 1'b0;
            redirectValid <= 1'b0;
            state         <= IDLE;
            stepCnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A single-cycle accept reloads the slot on the same
                    // edge that retires its previous contents.
                    if (accept && !isMult) begin
                        outValid      <= 1'b1;
                        aluResult     <= aluComb;
                        redirectValid <= redirComb;
                        redirectPC    <= nextPC;
                    end else if (outValid && outReady) begin
                        outValid      <= 1'b0;
                        redirectValid <= 1'b0;
                    end
                    if (accept && isMult) begin
                        mulA    <= regA;
                        mulB    <= opB;
                        mulAcc  <= '0;
                        mulPC   <= incrPC;
                        stepCnt <= '0;
                        state   <= MUL;
                    end
                end
                MUL: begin
                    if (outValid && outReady) begin
                        outValid      <= 1'b0;
                        redirectValid <= 1'b0;
                    end
                    mulAcc  <= stepAcc;
                    mulA    <= stepA;
                    mulB    <= stepB;
                    stepCnt <= stepCnt + 1'b1;
                    if (stepCnt == LAST_STEP) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (slotFree) begin
                        outValid      <= 1'b1;
                        aluResult     <= mulAcc;
                        redirectValid <= 1'b0;
                        redirectPC    <= mulPC;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    stepCnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/ex_stage_pipe.md
Name: ex_stage_pipe

Overview:
- Parametrised, pipelined successor to the combinational execute-stage control.
- Performs ALU operations and resolves next-PC from branch, jump and jump-register.
- Adds a valid/ready handshake, a registered EX/MEM output slot, flush support, selectable BEQ/BNE branch sense, and an iterative multi-cycle multiplier that stalls the upstream stage.
- Sits between the ID/EX register and the MEM stage.

Parameters:
- DATA_W, 32: datapath width; legal values 32 or 64.
- MUL_STEPS, DATA_W: shift-add iterations per multiply; legal range 1..DATA_W, bits processed per step = DATA_W/MUL_STEPS, must divide evenly.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- inValid  in  1  upstream presents an instruction
- inReady  out  1  stage can accept this cycle
- incrPC  in  DATA_W  PC+4 of the instruction
- regA  in  DATA_W  rs operand
- regB  in  DATA_W  rt operand
- extImm  in  DATA_W  sign-extended immediate
- target  in  26  J-type target field
- funct  in  6  R-type function field
- aluOp  in  2  00 add, 01 sub, 10 decode funct, 11 or
- aluSrc  in  1  1 selects extImm as operand B, 0 selects regB
- branch  in  1  conditional branch
- branchNe  in  1  1 = BNE sense, 0 = BEQ sense
- jump  in  1  J-type jump
- jumpR  in  1  jump to regA
- flush  in  1  kill the output slot and any in-flight multiply
- outReady  in  1  downstream accepts
- outValid  out  1  output slot holds a result
- aluResult  out  DATA_W  registered result
- redirectValid  out  1  registered: instruction changes the PC
- redirectPC  out  DATA_W  registered next PC

Behaviour:
- Reset (async, rst_n=0): outValid=0, redirectValid=0, aluResult=0, redirectPC=0, FSM=IDLE, step counter=0.
- Accept condition: inValid && inReady.
- inReady = (state==IDLE) && (!outValid || outReady) && !flush.
- Operand B = aluSrc ? extImm : regB.
- aluOp=10 funct decode:
  - 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed; result 1 or 0).
  - 0x18 mult: low DATA_W bits of the unsigned product, multi-cycle.
  - Any other funct value behaves as add.
- All arithmetic is modulo 2^DATA_W; no overflow traps.
- zero = (regA - opB == 0), evaluated at accept.
- Next PC, in priority order:
  - jumpR: regA.
  - else jump: {incrPC[DATA_W-1:28], target, 2'b00}.
  - else branch taken, i.e. branch && (branchNe ? !zero : zero): incrPC + (extImm<<2).
  - else: incrPC.
  - redirectValid=1 for the jumpR, jump and taken-branch cases.
- Single-cycle ops: result, redirectValid and redirectPC are loaded into the output slot on the accepting edge; outValid=1 the next cycle. Latency is 1.
- Slot retirement: the slot holds while outValid && !outReady. It clears (outValid=0) on outValid && outReady unless a new accept loads it on the same edge. Back-to-back throughput is 1 per cycle.
- FSM states IDLE, MUL, DONE:
  - IDLE -> MUL on accept of mult: latch operands, accumulator=0, counter=0; the output slot retires or holds per the normal rules.
  - MUL: one step per cycle, counter++. After MUL_STEPS steps -> DONE.
  - DONE: load the slot when (!outValid || outReady), then -> IDLE.
  - Total multiply latency is MUL_STEPS+1 cycles minimum. inReady=0 in MUL and DONE.
- Mult never redirects; redirectPC = incrPC.
- flush=1, highest priority on that edge: outValid=0, redirectValid=0, FSM->IDLE, counter=0, no accept.
- Reset mid-multiply: the operation is abandoned; no output is ever produced for it.
- redirectValid is meaningful only while outValid=1, and is cleared together with outValid.

Test Plan:
- Reset, then aluOp=00, regA=5, extImm=7, aluSrc=1, outReady=1 -> next cycle outValid=1, aluResult=12, redirectValid=0, redirectPC=incrPC.
- BEQ: branch=1, branchNe=0, regA=regB=0x10, incrPC=0x100, extImm=4 -> redirectValid=1, redirectPC=0x110. The same case with branchNe=1 -> redirectValid=0, redirectPC=0x100.
- jumpR=1, jump=1, regA=0x4000 -> redirectPC=0x4000 (jumpR wins). jump only with target=0x10, incrPC=0x30000004 -> redirectPC=0x30000040.
- mult with MUL_STEPS=32, regA=0xFFFF, regB=0x10001 -> inReady=0 for 33 cycles, then aluResult=0xFFFFFFFF; a new accept follows only after outValid.
- outReady=0 with outValid=1 and inValid=1 -> inReady=0 and the slot holds its value; raise outReady -> retire and accept on the same edge, with no bubble.
- flush during MUL cycle 5 -> outValid stays 0, FSM returns to IDLE, inReady=1 the next cycle. rst_n low mid-multiply -> all outputs 0 asynchronously.
